id_stage: RTL and testbench

Instruction-decode stage of the RV64I pipeline. Accepts a fetched instruction, drives register-file read addresses, decodes controls and immediate, applies write-back bypass and load-use hazard stalling, and registers the result into the ID/EX pipeline register consumed by the execute stage. Sits between the IF/ID register and the ALU/execute stage; the register file is read combinationally through this block.

---
 rtl/rv_pkg.sv | 74 +++++++
 rtl/imm_gen.sv | 40 ++++
 rtl/id_stage.sv | 166 ++++++++++++++++
 tb/tb_id_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : RV64I decode constants, control bundle and control decoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rv_pkg;

   localparam logic [6:0] c_opc_r      = 7'b0110011;
   localparam logic [6:0] c_opc_i      = 7'b0010011;
   localparam logic [6:0] c_opc_load   = 7'b0000011;
   localparam logic [6:0] c_opc_store  = 7'b0100011;
   localparam logic [6:0] c_opc_branch = 7'b1100011;

   localparam logic [1:0] c_aluop_add   = 2'b00;
   localparam logic [1:0] c_aluop_sub   = 2'b01;
   localparam logic [1:0] c_aluop_funct = 2'b10;

   typedef struct packed {
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       branch;
      logic       alusrc;
      logic [1:0] aluop;
   } ctrl_t;

   localparam ctrl_t c_ctrl_nop = '{default: '0};

   function automatic logic is_legal(input logic [6:0] opc);
      return (opc == c_opc_r) || (opc == c_opc_i) || (opc == c_opc_load) ||
             (opc == c_opc_store) || (opc == c_opc_branch);
   endfunction

   // Unsupported opcodes decode to an all-zero bundle so they travel as bubbles.
   function automatic ctrl_t decode_ctrl(input logic [6:0] opc);
      ctrl_t c;
      c = c_ctrl_nop;
      case (opc)
         c_opc_r: begin
            c.regwrite = 1'b1;
            c.aluop    = c_aluop_funct;
         end
         c_opc_i: begin
            c.regwrite = 1'b1;
            c.alusrc   = 1'b1;
            c.aluop    = c_aluop_funct;
         end
         c_opc_load: begin
            c.regwrite = 1'b1;
            c.memread  = 1'b1;
            c.memtoreg = 1'b1;
            c.alusrc   = 1'b1;
            c.aluop    = c_aluop_add;
         end
         c_opc_store: begin
            c.memwrite = 1'b1;
            c.alusrc   = 1'b1;
            c.aluop    = c_aluop_add;
         end
         c_opc_branch: begin
            c.branch   = 1'b1;
            c.aluop    = c_aluop_sub;
         end
         default: c = c_ctrl_nop;
      endcase
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/imm_gen.sv
// ============================================================================
// Module      : imm_gen
// Description : Sign-extended immediate extraction for I/S/B formats.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imm_gen
   import rv_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm
);

   logic [6:0] w_opcode;
   logic       w_unused;

   assign w_opcode = instr[6:0];
   assign w_unused = ^instr[19:12];

   always_comb begin
      imm = '0;
      case (w_opcode)
         c_opc_i, c_opc_load:
            imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
         c_opc_store:
            imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
         c_opc_branch:
            imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                   instr[11:8], 1'b0};
         default:
            imm = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================================
// Module      : id_stage
// Description : RV64I decode with write-back bypass, load-use stall, ID/EX reg.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module id_stage
   import rv_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int NREG_BITS = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_valid,
   input  logic [31:0]          if_instr,
   input  logic [XLEN-1:0]      if_pc,
   output logic                 id_ready,
   output logic [NREG_BITS-1:0] rs1,
   output logic [NREG_BITS-1:0] rs2,
   input  logic [XLEN-1:0]      rf_data1,
   input  logic [XLEN-1:0]      rf_data2,
   input  logic                 wb_regwrite,
   input  logic [NREG_BITS-1:0] wb_rd,
   input  logic [XLEN-1:0]      wb_data,
   input  logic                 flush,
   input  logic                 ex_ready,
   output logic                 ex_valid,
   output logic [XLEN-1:0]      ex_pc,
   output logic [XLEN-1:0]      ex_rs1_val,
   output logic [XLEN-1:0]      ex_rs2_val,
   output logic [XLEN-1:0]      ex_imm,
   output logic [NREG_BITS-1:0] ex_rs1,
   output logic [NREG_BITS-1:0] ex_rs2,
   output logic [NREG_BITS-1:0] ex_rd,
   output logic [3:0]           ex_funct,
   output logic                 ex_regwrite,
   output logic                 ex_memread,
   output logic                 ex_memwrite,
   output logic                 ex_memtoreg,
   output logic                 ex_branch,
   output logic                 ex_alusrc,
   output logic [1:0]           ex_aluop,
   output logic                 illegal_instr
);

   logic [6:0]           w_opcode;
   logic [NREG_BITS-1:0] w_rd;
   logic                 w_legal;
   logic                 w_use_rs2;
   logic                 w_hazard;
   ctrl_t                w_ctrl;
   logic [XLEN-1:0]      w_imm;
   logic [XLEN-1:0]      w_op1;
   logic [XLEN-1:0]      w_op2;

   logic                 r_valid;
   logic [XLEN-1:0]      r_pc;
   logic [XLEN-1:0]      r_rs1_val;
   logic [XLEN-1:0]      r_rs2_val;
   logic [XLEN-1:0]      r_imm;
   logic [NREG_BITS-1:0] r_rs1;
   logic [NREG_BITS-1:0] r_rs2;
   logic [NREG_BITS-1:0] r_rd;
   logic [3:0]           r_funct;
   ctrl_t                r_ctrl;
   logic                 r_illegal;

   assign w_opcode  = if_instr[6:0];
   assign rs1       = if_instr[15 +: NREG_BITS];
   assign rs2       = if_instr[20 +: NREG_BITS];
   assign w_rd      = if_instr[7 +: NREG_BITS];
   assign w_legal   = is_legal(w_opcode);
   assign w_ctrl    = decode_ctrl(w_opcode);
   assign w_use_rs2 = (w_opcode == c_opc_r) || (w_opcode == c_opc_store) ||
                      (w_opcode == c_opc_branch);

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (if_instr),
      .imm   (w_imm)
   );

   // A load in ID/EX cannot be bypassed; any consumer must wait one cycle.
   assign w_hazard = if_valid && r_valid && r_ctrl.memread && (r_rd != '0) &&
                     ((w_legal && (r_rd == rs1)) || (w_use_rs2 && (r_rd == rs2)));

   assign id_ready = !reset && (flush || (ex_ready && !w_hazard));

   always_comb begin
      w_op1 = rf_data1;
      w_op2 = rf_data2;
      if (rs1 == '0)
         w_op1 = '0;
      else if (wb_regwrite && (wb_rd == rs1))
         w_op1 = wb_data;
      if (rs2 == '0)
         w_op2 = '0;
      else if (wb_regwrite && (wb_rd == rs2))
         w_op2 = wb_data;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_valid   <= 1'b0;
         r_pc      <= '0;
         r_rs1_val <= '0;
         r_rs2_val <= '0;
         r_imm     <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_rd      <= '0;
         r_funct   <= '0;
         r_ctrl    <= c_ctrl_nop;
         r_illegal <= 1'b0;
      end else if (!ex_ready) begin
         r_illegal <= 1'b0;
      end else if (if_valid && !w_hazard && w_legal) begin
         r_valid   <= 1'b1;
         r_pc      <= if_pc;
         r_rs1_val <= w_op1;
         r_rs2_val <= w_op2;
         r_imm     <= w_imm;
         r_rs1     <= rs1;
         r_rs2     <= rs2;
         r_rd      <= w_rd;
         r_funct   <= {if_instr[30], if_instr[14:12]};
         r_ctrl    <= w_ctrl;
         r_illegal <= 1'b0;
      end else begin
         // Bubble: stall, empty IF/ID, or a dropped unsupported opcode.
         r_valid   <= 1'b0;
         r_pc      <= '0;
         r_rs1_val <= '0;
         r_rs2_val <= '0;
         r_imm     <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_rd      <= '0;
         r_funct   <= '0;
         r_ctrl    <= c_ctrl_nop;
         r_illegal <= if_valid && !w_hazard && !w_legal;
      end
   end

   assign ex_valid      = r_valid;
   assign ex_pc         = r_pc;
   assign ex_rs1_val    = r_rs1_val;
   assign ex_rs2_val    = r_rs2_val;
   assign ex_imm        = r_imm;
   assign ex_rs1        = r_rs1;
   assign ex_rs2        = r_rs2;
   assign ex_rd         = r_rd;
   assign ex_funct      = r_funct;
   assign ex_regwrite   = r_ctrl.regwrite;
   assign ex_memread    = r_ctrl.memread;
   assign ex_memwrite   = r_ctrl.memwrite;
   assign ex_memtoreg   = r_ctrl.memtoreg;
   assign ex_branch     = r_ctrl.branch;
   assign ex_alusrc     = r_ctrl.alusrc;
   assign ex_aluop      = r_ctrl.aluop;
   assign illegal_instr = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ============================================================================
// Module      : tb_id_stage
// Description : Directed self-checking bench for id_stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_id_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
   logic        id_ready;
   logic [4:0]  rs1, rs2;
   logic [63:0] rf_data1, rf_data2;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        flush;
   logic        ex_ready;
   logic        ex_valid;
   logic [63:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [3:0]  ex_funct;
   logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_alusrc;
   logic [1:0]  ex_aluop;
   logic        illegal_instr;

   int checks = 0;
   int errors = 0;

   id_stage #(.XLEN(64), .NREG_BITS(5)) dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready), .rs1(rs1), .rs2(rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
      .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
      .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
      .ex_branch(ex_branch), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
      .illegal_instr(illegal_instr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; if_valid = 1'b1; if_instr = 32'h002081B3; if_pc = 64'h100;
      rf_data1 = 64'd5; rf_data2 = 64'd7; wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
      flush = 1'b0; ex_ready = 1'b1;

      // reset held three cycles with a valid instruction waiting
      step(); step(); step();
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_ex_rd", ex_rd, 0);
      chk("rst_ex_regwrite", ex_regwrite, 0);
      chk("rst_ex_imm", ex_imm, 0);
      chk("rst_ex_pc", ex_pc, 0);
      chk("rst_illegal", illegal_instr, 0);
      chk("rst_id_ready", id_ready, 0);

      // add x3,x1,x2
      reset = 1'b0;
      #1;
      chk("add_rs1_addr", rs1, 1);
      chk("add_rs2_addr", rs2, 2);
      chk("add_id_ready", id_ready, 1);
      step();
      chk("add_valid", ex_valid, 1);
      chk("add_rd", ex_rd, 3);
      chk("add_rs1_val", ex_rs1_val, 5);
      chk("add_rs2_val", ex_rs2_val, 7);
      chk("add_aluop", ex_aluop, 2'b10);
      chk("add_regwrite", ex_regwrite, 1);
      chk("add_alusrc", ex_alusrc, 0);
      chk("add_pc", ex_pc, 64'h100);

      // sd x2,-8(x1)
      if_instr = 32'hFE20BC23; if_pc = 64'h104;
      step();
      chk("sd_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
      chk("sd_memwrite", ex_memwrite, 1);
      chk("sd_regwrite", ex_regwrite, 0);
      chk("sd_aluop", ex_aluop, 2'b00);
      chk("sd_alusrc", ex_alusrc, 1);
      chk("sd_funct", ex_funct, 4'b1011);

      // beq x1,x2,-4
      if_instr = 32'hFE208EE3; if_pc = 64'h108;
      step();
      chk("beq_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("beq_branch", ex_branch, 1);
      chk("beq_aluop", ex_aluop, 2'b01);
      chk("beq_regwrite", ex_regwrite, 0);

      // ld x5,0(x1) followed by dependent add x6,x5,x4
      if_instr = 32'h0000B283; if_pc = 64'h10C;
      step();
      chk("ld_valid", ex_valid, 1);
      chk("ld_memread", ex_memread, 1);
      chk("ld_memtoreg", ex_memtoreg, 1);
      chk("ld_rd", ex_rd, 5);
      if_instr = 32'h00428333; if_pc = 64'h110;
      #1;
      chk("hz_id_ready", id_ready, 0);
      step();
      chk("hz_bubble_valid", ex_valid, 0);
      chk("hz_bubble_memread", ex_memread, 0);
      chk("hz_id_ready_after", id_ready, 1);
      step();
      chk("hz_add_valid", ex_valid, 1);
      chk("hz_add_rd", ex_rd, 6);
      chk("hz_add_rs1", ex_rs1, 5);

      // hold: ex_ready low keeps ID/EX, no acceptance
      ex_ready = 1'b0; if_instr = 32'h00148513;
      #1;
      chk("hold_id_ready", id_ready, 0);
      step();
      chk("hold_rd", ex_rd, 6);
      chk("hold_valid", ex_valid, 1);
      ex_ready = 1'b1;

      // addi x10,x9,1 with write-back bypass of x9
      wb_regwrite = 1'b1; wb_rd = 5'd9; wb_data = 64'h99; rf_data1 = 64'd9;
      step();
      chk("byp_rs1_val", ex_rs1_val, 64'h99);
      chk("byp_imm", ex_imm, 64'd1);
      chk("byp_aluop", ex_aluop, 2'b10);
      // different write-back target: register file value used
      wb_rd = 5'd8;
      step();
      chk("nobyp_rs1_val", ex_rs1_val, 64'd9);
      // addi x10,x0,1: x0 reads zero even with write-back to x0
      if_instr = 32'h00100513; wb_rd = 5'd0; rf_data1 = 64'h55;
      step();
      chk("x0_rs1_val", ex_rs1_val, 64'd0);
      wb_regwrite = 1'b0;

      // flush while ex_ready low with unsupported opcode
      if_instr = 32'hFFFFFFFF; flush = 1'b1; ex_ready = 1'b0;
      #1;
      chk("fl_id_ready", id_ready, 1);
      step();
      chk("fl_valid", ex_valid, 0);
      chk("fl_illegal", illegal_instr, 0);
      chk("fl_regwrite", ex_regwrite, 0);

      // unsupported opcode without flush: dropped, one-cycle illegal pulse
      flush = 1'b0; ex_ready = 1'b1;
      step();
      chk("ill_valid", ex_valid, 0);
      chk("ill_pulse", illegal_instr, 1);
      if_valid = 1'b0;
      step();
      chk("ill_pulse_end", illegal_instr, 0);

      // reset during a load-use stall leaves nothing in ID/EX
      if_valid = 1'b1; if_instr = 32'h0000B283;
      step();
      chk("rs_ld_valid", ex_valid, 1);
      if_instr = 32'h00428333; ex_ready = 1'b0; reset = 1'b1;
      step();
      reset = 1'b0; if_valid = 1'b0;
      chk("rs_valid", ex_valid, 0);
      chk("rs_memread", ex_memread, 0);
      chk("rs_rd", ex_rd, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
